// File: rtl/sram_rr_scheduler_if.sv
// sram_rr_scheduler_if: requester handshakes and SRAM pad signals of the shared-SRAM scheduler
interface sram_rr_scheduler_if #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 36,
  parameter int BW_WIDTH   = 4
) ();
  logic                  rd_0_req, rd_1_req, rd_0_ack, rd_1_ack, rd_0_vld, rd_1_vld;
  logic [ADDR_WIDTH-1:0] rd_0_addr, rd_1_addr;
  logic [DATA_WIDTH-1:0] rd_0_data, rd_1_data;
  logic                  wr_0_req, wr_1_req, wr_0_ack, wr_1_ack;
  logic [ADDR_WIDTH-1:0] wr_0_addr, wr_1_addr;
  logic [DATA_WIDTH-1:0] wr_0_data, wr_1_data;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic                  sram_we, sram_tri_en;
  logic [BW_WIDTH-1:0]   sram_bw;
  logic [DATA_WIDTH-1:0] sram_wr_data, sram_rd_data;
  modport master (
    input  rd_0_req, rd_0_addr, rd_1_req, rd_1_addr,
    input  wr_0_req, wr_0_addr, wr_0_data, wr_1_req, wr_1_addr, wr_1_data, sram_rd_data,
    output rd_0_ack, rd_0_data, rd_0_vld, rd_1_ack, rd_1_data, rd_1_vld, wr_0_ack, wr_1_ack,
    output sram_addr, sram_we, sram_bw, sram_wr_data, sram_tri_en
  );
  modport slave (
    output rd_0_req, rd_0_addr, rd_1_req, rd_1_addr,
    output wr_0_req, wr_0_addr, wr_0_data, wr_1_req, wr_1_addr, wr_1_data, sram_rd_data,
    input  rd_0_ack, rd_0_data, rd_0_vld, rd_1_ack, rd_1_data, rd_1_vld, wr_0_ack, wr_1_ack,
    input  sram_addr, sram_we, sram_bw, sram_wr_data, sram_tri_en
  );
endinterface

// File: rtl/sram_rr_scheduler.sv
// sram_rr_scheduler: round-robin sharing of one NoBL SRAM between two read and two write requesters
module sram_rr_scheduler #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 36,
  parameter int BW_WIDTH   = 4,
  parameter int WR_DLY     = 2,
  parameter int RD_DLY     = 3
) (
  input logic clk,
  input logic reset_n,
  sram_rr_scheduler_if.master bus
);
  logic [3:0]                        req;
  logic [1:0]                        ptr_q, ptr_d, win;
  logic                              hit, wr_go, rd_go;
  logic [ADDR_WIDTH-1:0]             cmd_addr, addr_q, addr_d;
  logic [DATA_WIDTH-1:0]             cmd_data, wd_q, wd_d;
  logic [DATA_WIDTH-1:0]             r0_data_q, r0_data_d, r1_data_q, r1_data_d;
  logic                              we_q, we_d, tri_q, tri_d;
  logic                              r0_vld_q, r0_vld_d, r1_vld_q, r1_vld_d;
  logic [BW_WIDTH-1:0]               bw_q, bw_d;
  logic [WR_DLY-1:0]                 wv_q, wv_d;
  logic [WR_DLY-1:0][DATA_WIDTH-1:0] wp_q, wp_d;
  logic [RD_DLY-1:0]                 rv_q, rv_d, rid_q, rid_d;
  // source order rd_0, wr_0, rd_1, wr_1: bit 0 of the index marks a write, bit 1 the requester
  assign req = {bus.wr_1_req, bus.rd_1_req, bus.wr_0_req, bus.rd_0_req} & {4{reset_n}};
  always_comb begin
    win = ptr_q;
    hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!hit && req[ptr_q + 2'(i)]) begin
        hit = 1'b1;
        win = ptr_q + 2'(i);
      end
    end
  end
  assign {bus.wr_1_ack, bus.rd_1_ack, bus.wr_0_ack, bus.rd_0_ack} = hit ? 4'b1 << win : 4'b0;
  assign wr_go    = hit & win[0];
  assign rd_go    = hit & ~win[0];
  assign cmd_addr = win[1] ? (win[0] ? bus.wr_1_addr : bus.rd_1_addr)
                           : (win[0] ? bus.wr_0_addr : bus.rd_0_addr);
  assign cmd_data = win[1] ? bus.wr_1_data : bus.wr_0_data;
  // the tail stage of each pipe is the one due at this edge
  always_comb begin
    ptr_d     = hit ? win + 2'd1 : ptr_q;
    addr_d    = hit ? cmd_addr : addr_q;
    we_d      = ~wr_go;
    bw_d      = {BW_WIDTH{~wr_go}};
    wv_d      = WR_DLY'({wv_q, wr_go});
    wp_d      = (WR_DLY*DATA_WIDTH)'({wp_q, cmd_data});
    rv_d      = RD_DLY'({rv_q, rd_go});
    rid_d     = RD_DLY'({rid_q, win[1]});
    tri_d     = wv_q[WR_DLY-1];
    wd_d      = wv_q[WR_DLY-1] ? wp_q[WR_DLY-1] : wd_q;
    r0_vld_d  = rv_q[RD_DLY-1] & ~rid_q[RD_DLY-1];
    r1_vld_d  = rv_q[RD_DLY-1] & rid_q[RD_DLY-1];
    r0_data_d = r0_vld_d ? bus.sram_rd_data : r0_data_q;
    r1_data_d = r1_vld_d ? bus.sram_rd_data : r1_data_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q     <= '0;
      addr_q    <= '0;
      we_q      <= 1'b1;
      bw_q      <= '1;
      wv_q      <= '0;
      wp_q      <= '0;
      rv_q      <= '0;
      rid_q     <= '0;
      tri_q     <= 1'b0;
      wd_q      <= '0;
      r0_vld_q  <= 1'b0;
      r1_vld_q  <= 1'b0;
      r0_data_q <= '0;
      r1_data_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      bw_q      <= bw_d;
      wv_q      <= wv_d;
      wp_q      <= wp_d;
      rv_q      <= rv_d;
      rid_q     <= rid_d;
      tri_q     <= tri_d;
      wd_q      <= wd_d;
      r0_vld_q  <= r0_vld_d;
      r1_vld_q  <= r1_vld_d;
      r0_data_q <= r0_data_d;
      r1_data_q <= r1_data_d;
    end
  end
  assign bus.sram_addr    = addr_q;
  assign bus.sram_we      = we_q;
  assign bus.sram_bw      = bw_q;
  assign bus.sram_wr_data = wd_q;
  assign bus.sram_tri_en  = tri_q;
  assign bus.rd_0_vld     = r0_vld_q;
  assign bus.rd_1_vld     = r1_vld_q;
  assign bus.rd_0_data    = r0_data_q;
  assign bus.rd_1_data    = r1_data_q;
endmodule

// File: tb/tb_sram_rr_scheduler.sv
// tb_sram_rr_scheduler: directed tests of the scheduler against a pipelined NoBL SRAM model
module tb_sram_rr_scheduler;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_rr_scheduler_if #(.ADDR_WIDTH(19), .DATA_WIDTH(36), .BW_WIDTH(4)) bus ();
  sram_rr_scheduler #(.ADDR_WIDTH(19), .DATA_WIDTH(36), .BW_WIDTH(4), .WR_DLY(2), .RD_DLY(3)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  logic [3:0] acks;
  assign acks = {bus.wr_1_ack, bus.rd_1_ack, bus.wr_0_ack, bus.rd_0_ack};

  // SRAM: address sampled one edge after the command register, read data out one edge later,
  // write data taken two edges after the address with same-edge read forwarding
  logic [35:0] mem [256];
  logic        w0_v = 1'b0, w1_v = 1'b0;
  logic [7:0]  w0_a = '0, w1_a = '0, r_a = '0;
  always @(posedge clk) begin
    if (w1_v && bus.sram_tri_en) mem[w1_a] <= bus.sram_wr_data;
    bus.sram_rd_data <= (w1_v && bus.sram_tri_en && w1_a == r_a) ? bus.sram_wr_data : mem[r_a];
    w1_v <= w0_v;
    w1_a <= w0_a;
    w0_v <= !bus.sram_we;
    w0_a <= bus.sram_addr[7:0];
    r_a  <= bus.sram_addr[7:0];
  end

  logic [35:0] q0[$], q1[$];
  int          c0[$], c1[$];
  always @(negedge clk) begin
    if (bus.rd_0_vld) begin q0.push_back(bus.rd_0_data); c0.push_back(cyc); end
    if (bus.rd_1_vld) begin q1.push_back(bus.rd_1_data); c1.push_back(cyc); end
  end

  task automatic idle_reqs();
    bus.rd_0_req = 1'b0; bus.rd_1_req = 1'b0; bus.wr_0_req = 1'b0; bus.wr_1_req = 1'b0;
  endtask

  task automatic clear_q();
    q0.delete(); q1.delete(); c0.delete(); c1.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.rd_0_req = 1'b1; bus.rd_1_req = 1'b1; bus.wr_0_req = 1'b1; bus.wr_1_req = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      n_chk++; if (acks !== 4'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0000", acks); end
      n_chk++; if (bus.sram_we !== 1'b1) begin n_fail++; $display("FAIL reset_we: got %b expected 1", bus.sram_we); end
      n_chk++; if (bus.sram_tri_en !== 1'b0) begin n_fail++; $display("FAIL reset_tri: got %b expected 0", bus.sram_tri_en); end
      n_chk++; if (bus.sram_bw !== 4'hF) begin n_fail++; $display("FAIL reset_bw: got %h expected f", bus.sram_bw); end
      n_chk++; if (bus.sram_addr !== 19'd0 || bus.sram_wr_data !== 36'd0) begin
        n_fail++; $display("FAIL reset_addr_data: got %h/%h expected 0/0", bus.sram_addr, bus.sram_wr_data);
      end
      n_chk++; if ({bus.rd_0_vld, bus.rd_1_vld} !== 2'b00) begin
        n_fail++; $display("FAIL reset_vld: got %b expected 00", {bus.rd_0_vld, bus.rd_1_vld});
      end
    end
    @(negedge clk);
    idle_reqs();
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill_readback();
    int first_ack = 0;
    clear_q();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.wr_0_req = 1'b1; bus.wr_0_addr = 19'(i); bus.wr_0_data = 36'(i);
      #1;
      n_chk++; if (acks !== 4'b0010) begin n_fail++; $display("FAIL fill_ack[%0d]: got %b expected 0010", i, acks); end
    end
    @(negedge clk);
    bus.wr_0_req = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.rd_0_req = 1'b1; bus.rd_0_addr = 19'(i);
      #1;
      if (i == 0) first_ack = cyc;
      n_chk++; if (acks !== 4'b0001) begin n_fail++; $display("FAIL readback_ack[%0d]: got %b expected 0001", i, acks); end
    end
    @(negedge clk);
    bus.rd_0_req = 1'b0;
    repeat (8) @(negedge clk);
    n_chk++; if (q0.size() != 20 || q1.size() != 0) begin
      n_fail++; $display("FAIL readback_count: got %0d/%0d expected 20/0", q0.size(), q1.size());
    end
    for (int i = 0; i < 20 && i < q0.size(); i++) begin
      n_chk++; if (q0[i] !== 36'(i)) begin n_fail++; $display("FAIL readback_data[%0d]: got %h expected %h", i, q0[i], 36'(i)); end
    end
    n_chk++; if (c0.size() == 0 || c0[0] - first_ack != 4) begin
      n_fail++; $display("FAIL readback_latency: got %0d expected 4", c0.size() == 0 ? -1 : c0[0] - first_ack);
    end
    n_chk++; if (c0.size() != 20 || c0[19] - c0[0] != 19) begin
      n_fail++; $display("FAIL readback_spacing: got %0d vlds not back-to-back, expected 20 consecutive", c0.size());
    end
  endtask

  task automatic test_all_four();
    logic [3:0] e;
    clear_q();
    bus.rd_0_addr = 19'h10; bus.rd_1_addr = 19'h11;
    bus.wr_0_addr = 19'h40; bus.wr_0_data = 36'h111;
    bus.wr_1_addr = 19'h41; bus.wr_1_data = 36'h222;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) begin bus.rd_0_req = 1'b1; bus.rd_1_req = 1'b1; bus.wr_0_req = 1'b1; bus.wr_1_req = 1'b1; end
      #1;
      e = 4'(1 << ((1 + i) % 4));
      n_chk++; if (acks !== e) begin n_fail++; $display("FAIL rr_ack[%0d]: got %b expected %b", i, acks, e); end
    end
    @(negedge clk);
    idle_reqs();
    repeat (8) @(negedge clk);
    n_chk++; if (q0.size() != 3 || q1.size() != 3) begin
      n_fail++; $display("FAIL rr_vld_count: got %0d/%0d expected 3/3", q0.size(), q1.size());
    end
    n_chk++; if (q0.size() < 2 || q0[0] !== 36'd16 || q0[1] !== 36'd16 || c0[1] - c0[0] != 4) begin
      n_fail++; $display("FAIL rr_rd0: got %0d entries, expected data 16 every 4 cycles", q0.size());
    end
    n_chk++; if (q1.size() < 2 || q1[0] !== 36'd17 || q1[1] !== 36'd17 || c1[1] - c1[0] != 4) begin
      n_fail++; $display("FAIL rr_rd1: got %0d entries, expected data 17 every 4 cycles", q1.size());
    end
  endtask

  task automatic test_interleave();
    int k;
    clear_q();
    @(negedge clk);
    bus.wr_1_req = 1'b1; bus.wr_1_addr = 19'h5; bus.wr_1_data = 36'hABC;
    #1;
    k = cyc;
    n_chk++; if (acks !== 4'b1000) begin n_fail++; $display("FAIL il_wr_ack: got %b expected 1000", acks); end
    @(negedge clk);
    bus.wr_1_req = 1'b0; bus.rd_0_req = 1'b1; bus.rd_0_addr = 19'h5;
    #1;
    n_chk++; if (acks !== 4'b0001) begin n_fail++; $display("FAIL il_rd_ack: got %b expected 0001", acks); end
    n_chk++; if (bus.sram_we !== 1'b0 || bus.sram_bw !== 4'h0 || bus.sram_addr !== 19'h5) begin
      n_fail++; $display("FAIL il_wr_cmd: got we=%b bw=%h addr=%h expected 0/0/5", bus.sram_we, bus.sram_bw, bus.sram_addr);
    end
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (j == 0) bus.rd_0_req = 1'b0;
      #1;
      if (j == 0) begin
        n_chk++; if (bus.sram_we !== 1'b1 || bus.sram_bw !== 4'hF || bus.sram_addr !== 19'h5) begin
          n_fail++; $display("FAIL il_rd_cmd: got we=%b bw=%h addr=%h expected 1/f/5", bus.sram_we, bus.sram_bw, bus.sram_addr);
        end
      end
      n_chk++; if (bus.sram_tri_en !== (cyc == k + 3)) begin
        n_fail++; $display("FAIL il_tri_en[+%0d]: got %b expected %b", cyc - k, bus.sram_tri_en, cyc == k + 3);
      end
      if (cyc == k + 3) begin
        n_chk++; if (bus.sram_wr_data !== 36'hABC) begin n_fail++; $display("FAIL il_wr_data: got %h expected abc", bus.sram_wr_data); end
      end
    end
    n_chk++; if (q0.size() != 1 || q0[0] !== 36'hABC || c0[0] != k + 5 || q1.size() != 0) begin
      n_fail++; $display("FAIL il_rd_data: got %0d entries first %h expected one abc at +5", q0.size(), q0.size() ? q0[0] : 36'h0);
    end
  endtask

  task automatic test_routing();
    int j;
    clear_q();
    @(negedge clk);
    bus.rd_0_req = 1'b1; bus.rd_0_addr = 19'h1;
    #1;
    j = cyc;
    n_chk++; if (acks !== 4'b0001) begin n_fail++; $display("FAIL rt_ack0: got %b expected 0001", acks); end
    @(negedge clk);
    bus.rd_0_req = 1'b0; bus.rd_1_req = 1'b1; bus.rd_1_addr = 19'h2;
    #1;
    n_chk++; if (acks !== 4'b0100) begin n_fail++; $display("FAIL rt_ack1: got %b expected 0100", acks); end
    @(negedge clk);
    bus.rd_1_req = 1'b0;
    repeat (8) @(negedge clk);
    n_chk++; if (q0.size() != 1 || q0[0] !== 36'd1 || c0[0] != j + 4) begin
      n_fail++; $display("FAIL rt_rd0: got %0d entries first %h expected one 1 at +4", q0.size(), q0.size() ? q0[0] : 36'h0);
    end
    n_chk++; if (q1.size() != 1 || q1[0] !== 36'd2 || c1[0] != j + 5) begin
      n_fail++; $display("FAIL rt_rd1: got %0d entries first %h expected one 2 at +5", q1.size(), q1.size() ? q1[0] : 36'h0);
    end
  endtask

  task automatic test_midflight_reset();
    int m;
    clear_q();
    @(negedge clk);
    bus.rd_0_req = 1'b1; bus.rd_0_addr = 19'h3;
    #1;
    n_chk++; if (acks !== 4'b0001) begin n_fail++; $display("FAIL mf_ack: got %b expected 0001", acks); end
    @(negedge clk);
    bus.rd_0_req = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    n_chk++; if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++; $display("FAIL mf_dropped: got %0d/%0d vlds expected 0/0", q0.size(), q1.size());
    end
    @(negedge clk);
    bus.rd_1_req = 1'b1; bus.rd_1_addr = 19'h4;
    #1;
    m = cyc;
    n_chk++; if (acks !== 4'b0100) begin n_fail++; $display("FAIL mf_post_ack: got %b expected 0100", acks); end
    @(negedge clk);
    bus.rd_1_req = 1'b0;
    repeat (6) @(negedge clk);
    n_chk++; if (q1.size() != 1 || q1[0] !== 36'd4 || c1[0] != m + 4 || q0.size() != 0) begin
      n_fail++; $display("FAIL mf_post_read: got %0d entries first %h expected one 4 at +4", q1.size(), q1.size() ? q1[0] : 36'h0);
    end
  endtask

  initial begin
    idle_reqs();
    bus.rd_0_addr = '0; bus.rd_1_addr = '0; bus.wr_0_addr = '0; bus.wr_1_addr = '0;
    bus.wr_0_data = '0; bus.wr_1_data = '0;
    test_reset();
    test_fill_readback();
    test_all_four();
    test_interleave();
    test_routing();
    test_midflight_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
